// File: rtl/dma_addr_wc_regs.sv
// 8237A-style per-channel base/current address and word-count registers with byte-pointer
// CPU access, per-transfer stepping, terminal-count status and auto-initialize reload.
module dma_addr_wc_regs #(
  parameter int NUM_CH = 4,
  parameter int AW     = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [7:0]                 DataIn,
  output logic [7:0]                 DataOut,
  input  logic                       prog_wr,
  input  logic                       prog_rd,
  input  logic [3:0]                 reg_sel,
  input  logic                       master_clr,
  input  logic                       xfer_step,
  input  logic [$clog2(NUM_CH)-1:0]  xfer_chan,
  input  logic [NUM_CH-1:0]          addr_dec,
  input  logic [NUM_CH-1:0]          autoinit,
  output logic [AW-1:0]              Addr,
  output logic [AW-1:0]              WC,
  output logic [NUM_CH-1:0]          TC,
  input  logic                       tc_clr,
  output logic                       eop
);

  localparam int CW = $clog2(NUM_CH);
  localparam logic [3:0] NREG = 4'(2 * NUM_CH);

  logic [AW-1:0]     base_addr_q [NUM_CH];
  logic [AW-1:0]     base_addr_d [NUM_CH];
  logic [AW-1:0]     base_wc_q   [NUM_CH];
  logic [AW-1:0]     base_wc_d   [NUM_CH];
  logic [AW-1:0]     cur_addr_q  [NUM_CH];
  logic [AW-1:0]     cur_addr_d  [NUM_CH];
  logic [AW-1:0]     cur_wc_q    [NUM_CH];
  logic [AW-1:0]     cur_wc_d    [NUM_CH];
  logic              ptr_q, ptr_d;
  logic [NUM_CH-1:0] tc_q, tc_d;
  logic              eop_q, eop_d;

  logic          reg_hit, wr_hit, clr_all, ptr_clr, step_ok, tc_hit, sel_wc;
  logic [CW-1:0] sel_ch;
  logic [AW-1:0] rd_word, step_addr, step_wc;

  function automatic logic [AW-1:0] merge_byte(input logic [AW-1:0] old_val,
                                               input logic hi, input logic [7:0] b);
    logic [AW-1:0] v;
    v = old_val;
    if (hi) v[15:8] = b;
    else    v[7:0]  = b;
    return v;
  endfunction

  assign reg_hit = (reg_sel < NREG);
  assign sel_ch  = reg_sel[CW:1];
  assign sel_wc  = reg_sel[0];
  assign wr_hit  = prog_wr & reg_hit;
  assign clr_all = RESET | master_clr | (prog_wr & (reg_sel == 4'hD));
  assign ptr_clr = prog_wr & (reg_sel == 4'hC);
  // A CPU write to either register of the active channel suppresses that cycle's step.
  assign step_ok = xfer_step & ~(wr_hit & (sel_ch == xfer_chan));
  assign tc_hit  = step_ok & (cur_wc_q[xfer_chan] == '0);

  assign step_addr = addr_dec[xfer_chan] ? cur_addr_q[xfer_chan] - 1'b1
                                         : cur_addr_q[xfer_chan] + 1'b1;
  assign step_wc   = cur_wc_q[xfer_chan] - 1'b1;

  assign Addr = cur_addr_q[xfer_chan];
  assign WC   = cur_wc_q[xfer_chan];
  assign TC   = tc_q;
  assign eop  = eop_q;

  assign rd_word = sel_wc ? cur_wc_q[sel_ch] : cur_addr_q[sel_ch];
  assign DataOut = (prog_rd & reg_hit) ? (ptr_q ? rd_word[15:8] : rd_word[7:0]) : 8'h00;

  always_comb begin
    base_addr_d = base_addr_q;
    base_wc_d   = base_wc_q;
    cur_addr_d  = cur_addr_q;
    cur_wc_d    = cur_wc_q;
    ptr_d       = ptr_q;
    tc_d        = tc_clr ? '0 : tc_q;
    eop_d       = tc_hit;

    if (ptr_clr) begin
      ptr_d = 1'b0;
    end else if (wr_hit || (prog_rd && reg_hit)) begin
      ptr_d = ~ptr_q;
    end

    if (wr_hit) begin
      if (sel_wc) begin
        base_wc_d[sel_ch] = merge_byte(base_wc_q[sel_ch], ptr_q, DataIn);
        cur_wc_d[sel_ch]  = merge_byte(cur_wc_q[sel_ch], ptr_q, DataIn);
      end else begin
        base_addr_d[sel_ch] = merge_byte(base_addr_q[sel_ch], ptr_q, DataIn);
        cur_addr_d[sel_ch]  = merge_byte(cur_addr_q[sel_ch], ptr_q, DataIn);
      end
    end

    if (step_ok) begin
      if (tc_hit && autoinit[xfer_chan]) begin
        cur_addr_d[xfer_chan] = base_addr_q[xfer_chan];
        cur_wc_d[xfer_chan]   = base_wc_q[xfer_chan];
      end else begin
        cur_addr_d[xfer_chan] = step_addr;
        cur_wc_d[xfer_chan]   = step_wc;
      end
      if (tc_hit) tc_d[xfer_chan] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr_all) begin
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr_q[i] <= '0;
        base_wc_q[i]   <= '0;
        cur_addr_q[i]  <= '0;
        cur_wc_q[i]    <= '0;
      end
      ptr_q <= 1'b0;
      tc_q  <= '0;
      eop_q <= 1'b0;
    end else begin
      base_addr_q <= base_addr_d;
      base_wc_q   <= base_wc_d;
      cur_addr_q  <= cur_addr_d;
      cur_wc_q    <= cur_wc_d;
      ptr_q       <= ptr_d;
      tc_q        <= tc_d;
      eop_q       <= eop_d;
    end
  end

endmodule

// File: tb/tb_dma_addr_wc_regs.sv
// Bench for dma_addr_wc_regs: directed scenarios with literal expectations, then random
// traffic compared every cycle against a register-indexed behavioural model.
module tb_dma_addr_wc_regs;

  logic       CLK = 1'b0;
  logic       RESET, prog_wr, prog_rd, master_clr, xfer_step, tc_clr, eop;
  logic [7:0] DataIn, DataOut;
  logic [3:0] reg_sel, addr_dec, autoinit, TC;
  logic [1:0] xfer_chan;
  logic [15:0] Addr, WC;

  always #5 CLK = ~CLK;

  dma_addr_wc_regs #(.NUM_CH(4), .AW(16)) dut (
    .CLK(CLK), .RESET(RESET), .DataIn(DataIn), .DataOut(DataOut),
    .prog_wr(prog_wr), .prog_rd(prog_rd), .reg_sel(reg_sel), .master_clr(master_clr),
    .xfer_step(xfer_step), .xfer_chan(xfer_chan), .addr_dec(addr_dec), .autoinit(autoinit),
    .Addr(Addr), .WC(WC), .TC(TC), .tc_clr(tc_clr), .eop(eop)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: index r = register number (even = address, odd = word count of channel r/2).
  int m_base [8];
  int m_cur  [8];
  int m_ptr, m_tc, m_eop;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_dout();
    int w;
    if (prog_rd && reg_sel < 8) begin
      w = m_cur[reg_sel];
      return m_ptr ? (w / 256) % 256 : w % 256;
    end
    return 0;
  endfunction

  task automatic model_step();
    int c, a_idx, w_idx, hit, tcset, r;
    if (RESET || master_clr || (prog_wr && reg_sel == 13)) begin
      for (int i = 0; i < 8; i++) begin
        m_base[i] = 0;
        m_cur[i]  = 0;
      end
      m_ptr = 0; m_tc = 0; m_eop = 0;
      return;
    end
    hit   = (prog_wr && reg_sel < 8) ? 1 : 0;
    c     = int'(xfer_chan);
    a_idx = 2 * c;
    w_idx = 2 * c + 1;
    tcset = 0;
    r     = int'(reg_sel);
    if (xfer_step && !(hit && (r / 2) == c)) begin
      tcset = (m_cur[w_idx] == 0) ? 1 : 0;
      if (tcset && autoinit[c]) begin
        m_cur[a_idx] = m_base[a_idx];
        m_cur[w_idx] = m_base[w_idx];
      end else begin
        m_cur[a_idx] = addr_dec[c] ? (m_cur[a_idx] + 65535) % 65536 : (m_cur[a_idx] + 1) % 65536;
        m_cur[w_idx] = (m_cur[w_idx] + 65535) % 65536;
      end
    end
    if (prog_wr && r == 12) begin
      m_ptr = 0;
    end else if (hit) begin
      if (m_ptr == 0) begin
        m_base[r] = (m_base[r] / 256) * 256 + int'(DataIn);
        m_cur[r]  = (m_cur[r] / 256) * 256 + int'(DataIn);
      end else begin
        m_base[r] = m_base[r] % 256 + int'(DataIn) * 256;
        m_cur[r]  = m_cur[r] % 256 + int'(DataIn) * 256;
      end
      m_ptr = 1 - m_ptr;
    end else if (prog_rd && r < 8) begin
      m_ptr = 1 - m_ptr;
    end
    if (tc_clr) m_tc = 0;
    if (tcset) m_tc = m_tc | (1 << c);
    m_eop = tcset;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("Addr", int'(Addr), m_cur[2 * xfer_chan]);
      chk("WC", int'(WC), m_cur[2 * xfer_chan + 1]);
      chk("TC", int'(TC), m_tc);
      chk("eop", int'(eop), m_eop);
      chk("DataOut", int'(DataOut), exp_dout());
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    prog_wr = 0; prog_rd = 0; xfer_step = 0; tc_clr = 0; master_clr = 0; RESET = 0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [7:0] d);
    reg_sel = sel; DataIn = d; prog_wr = 1;
    tick();
  endtask

  task automatic rd_chk(input logic [3:0] sel, input int exp, input string name);
    reg_sel = sel; prog_rd = 1;
    #1;
    chk(name, int'(DataOut), exp);
    tick();
  endtask

  task automatic step(input logic [1:0] ch);
    xfer_chan = ch; xfer_step = 1;
    tick();
  endtask

  initial begin
    RESET = 1; prog_wr = 0; prog_rd = 0; master_clr = 0; xfer_step = 0; tc_clr = 0;
    DataIn = 0; reg_sel = 0; xfer_chan = 1; addr_dec = 0; autoinit = 0;
    for (int i = 0; i < 8; i++) begin
      m_base[i] = 0; m_cur[i] = 0;
    end
    m_ptr = 0; m_tc = 0; m_eop = 0;
    tick();
    RESET = 1;
    tick();
    chk_en = 1'b1;
    chk("reset_Addr", int'(Addr), 0);
    chk("reset_WC", int'(WC), 0);
    chk("reset_TC", int'(TC), 0);
    chk("reset_eop", int'(eop), 0);

    // Program channel 1 and read back through the byte pointer.
    wr(2, 8'h34); wr(2, 8'h12); wr(3, 8'h02); wr(3, 8'h00);
    rd_chk(2, 'h34, "rd_lo");
    rd_chk(2, 'h12, "rd_hi");
    chk("prog_Addr", int'(Addr), 'h1234);
    chk("prog_WC", int'(WC), 'h0002);

    // Three increments reach terminal count on the third.
    step(1); chk("s1_Addr", int'(Addr), 'h1235); chk("s1_WC", int'(WC), 1); chk("s1_eop", int'(eop), 0);
    step(1); chk("s2_Addr", int'(Addr), 'h1236); chk("s2_WC", int'(WC), 0); chk("s2_eop", int'(eop), 0);
    step(1); chk("s3_Addr", int'(Addr), 'h1237); chk("s3_WC", int'(WC), 'hFFFF);
    chk("s3_TC1", int'(TC[1]), 1); chk("s3_eop", int'(eop), 1);
    tick(); chk("eop_once", int'(eop), 0);
    step(1); chk("s4_eop", int'(eop), 0); chk("s4_Addr", int'(Addr), 'h1238);

    // Channel 0 auto-initialize with decrement from zero.
    wr(12, 0); wr(0, 0); wr(0, 0); wr(1, 0); wr(1, 0);
    addr_dec = 4'b0001; autoinit = 4'b0001;
    step(0);
    chk("ai_TC0", int'(TC[0]), 1); chk("ai_eop", int'(eop), 1);
    chk("ai_Addr", int'(Addr), 0); chk("ai_WC", int'(WC), 0);

    // Clear-pointer command between two byte writes.
    wr(0, 8'h11); wr(12, 0); wr(0, 8'hAA);
    chk("ptrclr_Addr", int'(Addr), 'h00AA);

    // tc_clr coinciding with a new terminal count keeps only the new bit.
    tc_clr = 1; tick(); chk("tcclr", int'(TC), 0);
    step(0); chk("tc0_set", int'(TC), 1);
    xfer_chan = 2; xfer_step = 1; tc_clr = 1; tick();
    chk("tc_clr_set", int'(TC), 4);

    // Write to channel 3 word count wins over a step on channel 3.
    wr(12, 0);
    reg_sel = 7; DataIn = 8'h55; prog_wr = 1; xfer_chan = 3; xfer_step = 1; tick();
    chk("wrwin_WC", int'(WC), 'h0055); chk("wrwin_Addr", int'(Addr), 0);
    chk("wrwin_TC3", int'(TC[3]), 0); chk("wrwin_eop", int'(eop), 0);

    RESET = 1; xfer_chan = 1; tick();
    chk("rst2_Addr", int'(Addr), 0); chk("rst2_WC", int'(WC), 0); chk("rst2_TC", int'(TC), 0);

    for (int n = 0; n < 3000; n++) begin
      RESET      = ($urandom_range(0, 299) == 0);
      master_clr = ($urandom_range(0, 299) == 0);
      prog_wr    = ($urandom_range(0, 3) == 0);
      prog_rd    = ($urandom_range(0, 3) == 0);
      reg_sel    = 4'($urandom_range(0, 15));
      if (reg_sel == 13 && $urandom_range(0, 9) != 0) reg_sel = 12;
      DataIn     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
      xfer_step  = ($urandom_range(0, 1) == 0);
      xfer_chan  = 2'($urandom_range(0, 3));
      tc_clr     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) begin
        addr_dec = 4'($urandom);
        autoinit = 4'($urandom);
      end
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
